// File: rtl/muldiv_hilo_pkg.sv
// rtl/muldiv_hilo_pkg.sv - ALU control codes, FSM states and helpers for muldiv_hilo
//
// Purpose: shared definitions for the execute-stage multiply/divide unit.
//   *_CONTROL : 5-bit alucontrol codes produced by the ALU decoder
//   md_state_e: multiply/divide sequencer states
//   DIV_ITERS : restoring-divider iteration count
package muldiv_hilo_pkg;

  localparam logic [4:0] MULT_CONTROL  = 5'b11000;
  localparam logic [4:0] MULTU_CONTROL = 5'b11001;
  localparam logic [4:0] DIV_CONTROL   = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b11011;
  localparam logic [4:0] MTHI_CONTROL  = 5'b11100;
  localparam logic [4:0] MTLO_CONTROL  = 5'b11101;
  localparam logic [4:0] MFHI_CONTROL  = 5'b11110;
  localparam logic [4:0] MFLO_CONTROL  = 5'b11111;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is
  // exactly the unsigned magnitude the divider needs.
  function automatic logic [31:0] mag32(input logic is_signed, input logic [31:0] v);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_hilo_div_radix2.sv
// rtl/muldiv_hilo_div_radix2.sv - iterative restoring radix-2 unsigned divider
//
// Purpose: 32-cycle unsigned divide of magnitudes, one quotient bit per cycle.
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   start               load dividend/divisor and begin iterating
//   cancel              abandon the operation in progress
//   dividend, divisor   32-bit unsigned operands
//   done                high during the final iteration cycle
//   quotient, remainder results, stable once done has been seen
module div_radix2
  import muldiv_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;
  logic [32:0] trial;
  logic [32:0] diff;

  assign done      = busy_q && (cnt_q == 5'(DIV_ITERS - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    // Dividend bits are shifted out of the quotient register into the
    // partial remainder as quotient bits are shifted in.
    trial  = {rem_q, quo_q[31]};
    diff   = trial - {1'b0, dsr_q};
    if (cancel) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend;
      rem_d  = '0;
      dsr_d  = divisor;
    end else if (busy_q) begin
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - execute-stage multiply/divide unit with HI/LO registers
//
// Purpose: runs MULT/MULTU/DIV/DIVU, handles MTHI/MTLO, stalls the pipeline
// while an operation is in flight and exposes committed HI/LO.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   alucontrol[4:0]  E-stage ALU control code
//   e_valid          E-stage instruction is not a bubble
//   src_a, src_b     rs / rt operand values
//   stall_in         pipeline held by another source
//   flush            cancels the E-stage operation
//   stall_o          hold request while a mul/div is busy
//   hi_o, lo_o       committed HI / LO
module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  alucontrol,
  input  logic        e_valid,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        stall_in,
  input  logic        flush,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_e   state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d, div_q, div_d;
  logic [1:0]  mcnt_q, mcnt_d;
  logic [63:0] prod_q, prod_d;

  logic        is_mul_op, is_div_op, op_signed, start, mt_ok;
  logic [63:0] a64, b64;
  logic        div_done;
  logic [31:0] div_quo, div_rem, quo_fix, rem_fix;

  always_comb begin
    is_mul_op = (alucontrol == MULT_CONTROL) || (alucontrol == MULTU_CONTROL);
    is_div_op = (alucontrol == DIV_CONTROL)  || (alucontrol == DIVU_CONTROL);
    op_signed = (alucontrol == MULT_CONTROL) || (alucontrol == DIV_CONTROL);
    start     = e_valid && !flush && (state_q == MD_IDLE) && (is_mul_op || is_div_op);
    mt_ok     = e_valid && !flush && !stall_in && (state_q == MD_IDLE);
  end

  assign stall_o = !flush && (start || state_q == MD_MUL || state_q == MD_DIV);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  // Low 64 bits of the product of sign/zero-extended operands are correct
  // for both signed and unsigned multiply.
  assign a64 = {{32{sgn_q & a_q[31]}}, a_q};
  assign b64 = {{32{sgn_q & b_q[31]}}, b_q};

  div_radix2 u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start && is_div_op),
    .cancel    (flush),
    .dividend  (mag32(op_signed, src_a)),
    .divisor   (mag32(op_signed, src_b)),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Quotient is negative when operand signs differ; remainder follows the dividend.
  assign quo_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? (~div_quo + 32'd1) : div_quo;
  assign rem_fix = (sgn_q && a_q[31]) ? (~div_rem + 32'd1) : div_rem;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    div_d   = div_q;
    mcnt_d  = mcnt_q;
    prod_d  = prod_q;
    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            a_d     = src_a;
            b_d     = src_b;
            sgn_d   = op_signed;
            div_d   = is_div_op;
            mcnt_d  = '0;
            state_d = is_div_op ? MD_DIV : MD_MUL;
          end else if (mt_ok && alucontrol == MTHI_CONTROL) begin
            hi_d = src_a;
          end else if (mt_ok && alucontrol == MTLO_CONTROL) begin
            lo_d = src_a;
          end
        end
        MD_MUL: begin
          prod_d = a64 * b64;
          mcnt_d = mcnt_q + 2'd1;
          if (mcnt_q == 2'(MUL_STAGES - 1)) state_d = MD_DONE;
        end
        MD_DIV: begin
          if (div_done) state_d = MD_DONE;
        end
        MD_DONE: begin
          // Commit only when the instruction actually leaves E.
          if (!stall_in) begin
            state_d = MD_IDLE;
            if (!div_q) begin
              {hi_d, lo_d} = prod_q;
            end else if (b_q == 32'd0) begin
              hi_d = a_q;
              lo_d = 32'hFFFF_FFFF;
            end else begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
          end
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= MD_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      div_q   <= 1'b0;
      mcnt_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      div_q   <= div_d;
      mcnt_q  <= mcnt_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - self-checking scoreboard bench for muldiv_hilo
module tb_muldiv_hilo;
  import muldiv_hilo_pkg::*;

  localparam int MS = 2;
  localparam logic [4:0] NOP_CONTROL = 5'b00010;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  alucontrol;
  logic        e_valid;
  logic [31:0] src_a, src_b;
  logic        stall_in, flush;
  logic        stall_o;
  logic [31:0] hi_o, lo_o;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m_hilo;
  int          hilo_changes = 0;
  logic [63:0] prev_hilo = '0;

  muldiv_hilo #(.MUL_STAGES(MS)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .alucontrol (alucontrol),
    .e_valid    (e_valid),
    .src_a      (src_a),
    .src_b      (src_b),
    .stall_in   (stall_in),
    .flush      (flush),
    .stall_o    (stall_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ({hi_o, lo_o} !== prev_hilo) hilo_changes++;
    prev_hilo = {hi_o, lo_o};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (c)
      MULT_CONTROL:  res = 64'(sa * sb);
      MULTU_CONTROL: res = {32'd0, a} * {32'd0, b};
      DIV_CONTROL: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      DIVU_CONTROL: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int hold);
    int n;
    int exp_stall;
    logic [63:0] want;
    exp_stall = (c == DIV_CONTROL || c == DIVU_CONTROL) ? 33 : MS + 1;
    exp_q.push_back(exp);
    alucontrol = c; src_a = a; src_b = b; e_valid = 1'b1; stall_in = (hold > 0);
    n = 0;
    @(negedge clk);
    while (stall_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (i > 0) @(negedge clk);
        chk({tag, "_hold_stall"}, 64'(stall_o), 64'd0);
        chk({tag, "_hold_hilo"}, {hi_o, lo_o}, m_hilo);
      end
      @(posedge clk); #1;
      stall_in = 1'b0;
    end
    @(posedge clk); #1;
    e_valid = 1'b0; alucontrol = NOP_CONTROL;
    @(negedge clk);
    want = exp_q.pop_front();
    chk({tag, "_hilo"}, {hi_o, lo_o}, want);
    chk({tag, "_no_restart"}, 64'(stall_o), 64'd0);
    m_hilo = want;
    @(posedge clk); #1;
  endtask

  task automatic run_mt(input string tag, input logic [4:0] c, input logic [31:0] a, input int hold);
    logic [63:0] want;
    want = (c == MTHI_CONTROL) ? {a, m_hilo[31:0]} : {m_hilo[63:32], a};
    exp_q.push_back(want);
    alucontrol = c; src_a = a; e_valid = 1'b1; stall_in = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_held_hilo"}, {hi_o, lo_o}, m_hilo);
      @(posedge clk); #1;
    end
    stall_in = 1'b0;
    @(posedge clk); #1;
    alucontrol = (c == MTHI_CONTROL) ? MFHI_CONTROL : MFLO_CONTROL;
    src_a = 32'd0;
    @(negedge clk);
    want = exp_q.pop_front();
    chk({tag, "_hilo"}, {hi_o, lo_o}, want);
    chk({tag, "_mf_stall"}, 64'(stall_o), 64'd0);
    m_hilo = want;
    @(posedge clk); #1;
    e_valid = 1'b0; alucontrol = NOP_CONTROL;
  endtask

  initial begin
    int c0;
    logic [4:0] ops[4];
    logic [4:0] c;
    logic [31:0] a, b;
    ops[0] = MULT_CONTROL; ops[1] = MULTU_CONTROL; ops[2] = DIV_CONTROL; ops[3] = DIVU_CONTROL;

    resetn = 1'b0; alucontrol = NOP_CONTROL; e_valid = 1'b0;
    src_a = '0; src_b = '0; stall_in = 1'b0; flush = 1'b0;
    m_hilo = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_hilo", {hi_o, lo_o}, 64'd0);
    chk("reset_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op("mult",  MULT_CONTROL,  32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 0);
    run_op("multu", MULTU_CONTROL, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 0);
    run_op("div",   DIV_CONTROL,   32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("divu",  DIVU_CONTROL,  32'd100, 32'd7, 64'h0000_0002_0000_000E, 0);
    run_op("div_ovf", DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
    run_op("div0",  DIV_CONTROL,   32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 0);

    c0 = hilo_changes;
    run_op("hold",  MULTU_CONTROL, 32'd5, 32'd6, 64'h0000_0000_0000_001E, 5);
    chk("hold_writes", 64'(hilo_changes - c0), 64'd1);

    for (int i = 0; i < 6; i++) begin
      c = ops[i % 4];
      a = $urandom;
      b = (i >= 4) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op("rand", c, a, b, model(c, a, b), 0);
    end

    // flush at the 10th stall cycle of a DIV
    alucontrol = DIV_CONTROL; src_a = 32'd1000; src_b = 32'd3; e_valid = 1'b1;
    @(negedge clk);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; e_valid = 1'b0; alucontrol = NOP_CONTROL;
    @(negedge clk);
    chk("flush_hilo", {hi_o, lo_o}, m_hilo);
    chk("flush_idle_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    run_mt("mtlo_after_flush", MTLO_CONTROL, 32'h0000_BEEF, 0);

    // flush together with start
    alucontrol = MULT_CONTROL; src_a = 32'd7; src_b = 32'd9; e_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_start_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; e_valid = 1'b0; alucontrol = NOP_CONTROL;
    @(negedge clk);
    chk("flush_start_stall2", 64'(stall_o), 64'd0);
    chk("flush_start_hilo", {hi_o, lo_o}, m_hilo);
    @(posedge clk); #1;

    // unrelated control code
    alucontrol = NOP_CONTROL; src_a = 32'h5555_5555; src_b = 32'd1; e_valid = 1'b1;
    @(negedge clk);
    chk("nop_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    e_valid = 1'b0;
    @(negedge clk);
    chk("nop_hilo", {hi_o, lo_o}, m_hilo);
    @(posedge clk); #1;

    run_mt("mthi", MTHI_CONTROL, 32'h0000_CAFE, 0);
    run_mt("mtlo_stalled", MTLO_CONTROL, 32'h1357_9BDF, 3);

    // reset in the middle of a DIV
    alucontrol = DIV_CONTROL; src_a = 32'd12345; src_b = 32'd17; e_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    resetn = 1'b0; e_valid = 1'b0; alucontrol = NOP_CONTROL;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midreset_hilo", {hi_o, lo_o}, 64'd0);
    chk("midreset_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    m_hilo = '0;
    @(posedge clk); #1;
    run_op("post_reset_mult", MULT_CONTROL, 32'h0000_0010, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0, 0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
